// File: rtl/bsg_manycore_store_credit_ctrl.sv
// rtl/bsg_manycore_store_credit_ctrl.sv - outstanding remote-store credit tracking, throttling and store fence
module bsg_manycore_store_credit_ctrl #(
    parameter int max_out_p    = 16,
    parameter int timeout_p    = 1024,
    localparam int cnt_width_lp = $clog2(max_out_p + 1),
    localparam int wd_width_lp  = (timeout_p > 0) ? $clog2(timeout_p + 1) : 1
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic                    freeze_i,
    input  logic                    core_v_i,
    input  logic                    core_is_store_i,
    output logic                    core_ready_o,
    output logic                    net_v_o,
    input  logic                    net_ready_i,
    input  logic                    ret_v_i,
    output logic                    ret_ready_o,
    input  logic                    fence_req_i,
    output logic                    fence_done_o,
    output logic [cnt_width_lp-1:0] outstanding_o,
    output logic                    err_underflow_o,
    output logic                    err_timeout_o
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    localparam logic [cnt_width_lp-1:0] max_cnt_lp = cnt_width_lp'(max_out_p);
    localparam logic [wd_width_lp-1:0]  wd_max_lp  = wd_width_lp'(timeout_p);

    state_e                  state_q, state_d;
    logic [cnt_width_lp-1:0] cnt_q, cnt_d;
    logic [wd_width_lp-1:0]  wd_q, wd_d;
    logic                    uf_q, uf_d;
    logic                    to_q, to_d;

    logic block_st;
    logic pass;
    logic inc;
    logic dec;

    // Freed credits only count from the next cycle: blocking looks at the registered count.
    assign block_st = core_is_store_i & ((state_q != ST_IDLE) | (cnt_q == max_cnt_lp));
    assign pass     = reset_i & ~freeze_i & ~block_st;

    assign net_v_o      = core_v_i & pass;
    assign core_ready_o = net_ready_i & pass;
    assign ret_ready_o  = reset_i;

    assign inc = core_v_i & core_is_store_i & core_ready_o;
    assign dec = ret_v_i & ret_ready_o;

    always_comb begin
        cnt_d = cnt_q;
        uf_d  = uf_q;
        if (inc & ~dec) begin
            cnt_d = cnt_q + cnt_width_lp'(1);
        end else if (dec & ~inc) begin
            if (cnt_q != '0) begin
                cnt_d = cnt_q - cnt_width_lp'(1);
            end else begin
                uf_d = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        wd_d    = wd_q;
        to_d    = to_q;
        case (state_q)
            ST_IDLE: begin
                wd_d = '0;
                if (fence_req_i) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (cnt_q == '0) begin
                    state_d = ST_DONE;
                end else if ((timeout_p != 0) && (wd_q != wd_max_lp)) begin
                    wd_d = wd_q + wd_width_lp'(1);
                    if (wd_d == wd_max_lp) begin
                        to_d = 1'b1;
                    end
                end
            end
            ST_DONE: begin
                wd_d    = '0;
                state_d = ST_IDLE;
            end
            default: begin
                wd_d    = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            wd_q    <= '0;
            uf_q    <= 1'b0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wd_q    <= wd_d;
            uf_q    <= uf_d;
            to_q    <= to_d;
        end
    end

    assign fence_done_o    = (state_q == ST_DONE);
    assign outstanding_o   = cnt_q;
    assign err_underflow_o = uf_q;
    assign err_timeout_o   = to_q;

endmodule

// File: tb/tb_bsg_manycore_store_credit_ctrl.sv
// tb/tb_bsg_manycore_store_credit_ctrl.sv - directed vector bench for bsg_manycore_store_credit_ctrl
module tb_bsg_manycore_store_credit_ctrl;

    logic       clk = 1'b0;
    logic       reset_i;
    logic       freeze_i, core_v_i, core_is_store_i, net_ready_i, ret_v_i, fence_req_i;
    logic       core_ready_o, net_v_o, ret_ready_o, fence_done_o;
    logic [2:0] outstanding_o;
    logic       err_underflow_o, err_timeout_o;

    int pass_cnt  = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    bsg_manycore_store_credit_ctrl #(
        .max_out_p(4),
        .timeout_p(8)
    ) dut (
        .clk_i          (clk),
        .reset_i        (reset_i),
        .freeze_i       (freeze_i),
        .core_v_i       (core_v_i),
        .core_is_store_i(core_is_store_i),
        .core_ready_o   (core_ready_o),
        .net_v_o        (net_v_o),
        .net_ready_i    (net_ready_i),
        .ret_v_i        (ret_v_i),
        .ret_ready_o    (ret_ready_o),
        .fence_req_i    (fence_req_i),
        .fence_done_o   (fence_done_o),
        .outstanding_o  (outstanding_o),
        .err_underflow_o(err_underflow_o),
        .err_timeout_o  (err_timeout_o)
    );

    typedef struct {
        logic fr, cv, st, nr, rv, fq;
        logic nv, cr, fd;
        int   cnt;
        logic euf, eto;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string nm, input int act, input int exp);
        total_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d required %0d", nm, act, exp);
    endtask

    task automatic set_in(input logic fr, cv, st, nr, rv, fq);
        freeze_i = fr; core_v_i = cv; core_is_store_i = st;
        net_ready_i = nr; ret_v_i = rv; fence_req_i = fq;
    endtask

    // One cycle: drive just after the rising edge, leave the caller at the falling edge.
    task automatic cyc(input logic fr, cv, st, nr, rv, fq);
        @(posedge clk);
        #1;
        set_in(fr, cv, st, nr, rv, fq);
        @(negedge clk);
    endtask

    task automatic add(input logic fr, cv, st, nr, rv, fq, nv, cr, fd,
                       input int cnt, input logic euf, eto);
        vecs.push_back('{fr, cv, st, nr, rv, fq, nv, cr, fd, cnt, euf, eto});
    endtask

    initial begin
        // fr cv st nr rv fq | nv cr fd cnt euf eto
        add(0,1,1,1,0,0, 1,1,0,0, 0,0);
        add(0,1,1,1,0,0, 1,1,0,1, 0,0);
        add(0,1,1,1,0,0, 1,1,0,2, 0,0);
        add(0,0,0,1,0,0, 0,1,0,3, 0,0);
        add(0,0,0,1,1,0, 0,1,0,3, 0,0);
        add(0,0,0,1,1,0, 0,1,0,2, 0,0);
        add(0,0,0,1,1,0, 0,1,0,1, 0,0);
        add(0,0,0,1,0,0, 0,1,0,0, 0,0);
        add(0,1,1,1,0,0, 1,1,0,0, 0,0);
        add(0,1,1,1,0,0, 1,1,0,1, 0,0);
        add(0,1,1,1,0,0, 1,1,0,2, 0,0);
        add(0,1,1,1,0,0, 1,1,0,3, 0,0);
        add(0,1,1,1,0,0, 0,0,0,4, 0,0);
        add(0,1,1,1,1,0, 0,0,0,4, 0,0);
        add(0,1,1,1,0,0, 1,1,0,3, 0,0);
        add(0,1,1,1,0,0, 0,0,0,4, 0,0);
        add(0,0,0,1,1,0, 0,1,0,4, 0,0);
        add(0,0,0,1,1,0, 0,1,0,3, 0,0);
        add(0,1,1,1,1,0, 1,1,0,2, 0,0);
        add(0,0,0,1,0,0, 0,1,0,2, 0,0);
        add(0,0,0,1,0,1, 0,1,0,2, 0,0);
        add(0,1,1,1,0,0, 0,0,0,2, 0,0);
        add(0,1,0,1,1,0, 1,1,0,2, 0,0);
        add(0,0,0,1,0,0, 0,1,0,1, 0,0);
        add(0,0,0,1,0,0, 0,1,0,1, 0,0);
        add(0,0,0,1,0,0, 0,1,0,1, 0,0);
        add(0,0,0,1,1,0, 0,1,0,1, 0,0);
        add(0,0,0,1,0,0, 0,1,0,0, 0,0);
        add(0,0,0,1,0,0, 0,1,1,0, 0,0);
        add(0,1,1,1,0,0, 1,1,0,0, 0,0);
        add(0,0,0,1,1,0, 0,1,0,1, 0,0);
        add(0,0,0,1,0,1, 0,1,0,0, 0,0);
        add(0,0,0,1,0,1, 0,1,0,0, 0,0);
        add(0,0,0,1,0,0, 0,1,1,0, 0,0);
        add(0,0,0,1,0,0, 0,1,0,0, 0,0);
        add(1,1,1,1,0,0, 0,0,0,0, 0,0);
        add(1,1,0,1,0,0, 0,0,0,0, 0,0);
        add(0,0,0,1,1,0, 0,1,0,0, 0,0);
        add(0,0,0,1,0,0, 0,1,0,0, 1,0);
        add(0,1,1,1,1,0, 1,1,0,0, 1,0);
        add(0,0,0,1,0,0, 0,1,0,0, 1,0);

        reset_i = 1'b0;
        set_in(0, 1, 0, 1, 1, 0);
        @(negedge clk);
        chk("rst net_v", net_v_o, 0);
        chk("rst core_ready", core_ready_o, 0);
        chk("rst ret_ready", ret_ready_o, 0);
        chk("rst outstanding", outstanding_o, 0);
        chk("rst fence_done", fence_done_o, 0);
        chk("rst err_uf", err_underflow_o, 0);
        chk("rst err_to", err_timeout_o, 0);
        set_in(0, 0, 0, 0, 0, 0);
        reset_i = 1'b1;

        foreach (vecs[i]) begin
            cyc(vecs[i].fr, vecs[i].cv, vecs[i].st, vecs[i].nr, vecs[i].rv, vecs[i].fq);
            chk($sformatf("v%0d net_v", i), net_v_o, vecs[i].nv);
            chk($sformatf("v%0d core_ready", i), core_ready_o, vecs[i].cr);
            chk($sformatf("v%0d ret_ready", i), ret_ready_o, 1);
            chk($sformatf("v%0d fence_done", i), fence_done_o, vecs[i].fd);
            chk($sformatf("v%0d outstanding", i), outstanding_o, vecs[i].cnt);
            chk($sformatf("v%0d err_uf", i), err_underflow_o, vecs[i].euf);
            chk($sformatf("v%0d err_to", i), err_timeout_o, vecs[i].eto);
        end

        // Watchdog: fence with one store outstanding and no ack.
        cyc(0, 1, 1, 1, 0, 0);
        cyc(0, 0, 0, 1, 0, 1);
        chk("to fence cnt", outstanding_o, 1);
        for (int k = 1; k <= 8; k++) begin
            cyc(0, 0, 0, 1, 0, 0);
            chk($sformatf("to drain%0d err_to", k), err_timeout_o, 0);
            chk($sformatf("to drain%0d fence_done", k), fence_done_o, 0);
        end
        cyc(0, 0, 0, 1, 0, 0);
        chk("to set err_to", err_timeout_o, 1);
        chk("to set cnt", outstanding_o, 1);
        cyc(0, 1, 1, 1, 0, 0);
        chk("to drain store blocked", net_v_o, 0);
        cyc(0, 0, 0, 1, 1, 0);
        chk("to ack cnt", outstanding_o, 1);
        cyc(0, 0, 0, 1, 0, 0);
        chk("to ack+1 cnt", outstanding_o, 0);
        chk("to ack+1 fence_done", fence_done_o, 0);
        cyc(0, 0, 0, 1, 0, 0);
        chk("to ack+2 fence_done", fence_done_o, 1);
        chk("to ack+2 err_to", err_timeout_o, 1);
        cyc(0, 0, 0, 1, 0, 0);
        chk("to ack+3 fence_done", fence_done_o, 0);
        chk("to sticky err_uf", err_underflow_o, 1);

        // Asynchronous reset in the middle of a drain with three stores outstanding.
        cyc(0, 1, 1, 1, 0, 0);
        cyc(0, 1, 1, 1, 0, 0);
        cyc(0, 1, 1, 1, 0, 0);
        cyc(0, 0, 0, 1, 0, 1);
        cyc(0, 1, 0, 1, 0, 0);
        chk("mid drain cnt", outstanding_o, 3);
        chk("mid drain load", net_v_o, 1);
        #2;
        reset_i = 1'b0;
        #1;
        chk("async rst cnt", outstanding_o, 0);
        chk("async rst net_v", net_v_o, 0);
        chk("async rst core_ready", core_ready_o, 0);
        chk("async rst ret_ready", ret_ready_o, 0);
        chk("async rst err_uf", err_underflow_o, 0);
        chk("async rst err_to", err_timeout_o, 0);
        chk("async rst fence_done", fence_done_o, 0);
        set_in(0, 0, 0, 0, 0, 0);
        #1;
        reset_i = 1'b1;
        cyc(0, 1, 1, 1, 0, 0);
        chk("post rst store net_v", net_v_o, 1);
        chk("post rst store core_ready", core_ready_o, 1);
        cyc(0, 0, 0, 1, 0, 0);
        chk("post rst cnt", outstanding_o, 1);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/bsg_manycore_store_credit_ctrl.md
Name: bsg_manycore_store_credit_ctrl

Overview:
- Sits between the tile processor's request output and the request mesh router.
- Tracks outstanding remote stores: +1 on each store accepted by the router, −1 on each return-network acknowledgement.
- Throttles the core when the outstanding-store limit is reached.
- Runs a store-fence sequence (drain to zero, then signal done) so software can confirm that remote stores have completed.

Parameters:
- max_out_p, 16: maximum outstanding remote stores; must be ≥1.
- timeout_p, 1024: cycles allowed in DRAIN before the watchdog error sets; 0 disables the watchdog.
- cnt_width_lp, $clog2(max_out_p+1): width of the outstanding counter (derived).
- wd_width_lp, `BSG_SAFE_CLOG2(timeout_p+1): width of the watchdog counter (derived).

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- reset_i  in  1  asynchronous, active-low reset.
- freeze_i  in  1  tile freeze; blocks all sends when 1.
- core_v_i  in  1  core request valid.
- core_is_store_i  in  1  request is a remote store; qualified by core_v_i.
- core_ready_o  out  1  request accepted this cycle when core_v_i & core_ready_o.
- net_v_o  out  1  valid to router processor port.
- net_ready_i  in  1  router processor-port ready.
- ret_v_i  in  1  return-network ack valid (one ack per store).
- ret_ready_o  out  1  ack consumed.
- fence_req_i  in  1  fence request; sampled only in IDLE.
- fence_done_o  out  1  one-cycle pulse: all stores issued before the fence are acked.
- outstanding_o  out  cnt_width_lp  current outstanding count.
- err_underflow_o  out  1  sticky: ack received with count 0 and no simultaneous store.
- err_timeout_o  out  1  sticky: DRAIN exceeded timeout_p cycles.

Behaviour:
- Reset (reset_i=0, asynchronous): count=0, state=IDLE, watchdog=0, fence_done_o=0, both error flags=0. While reset_i=0, net_v_o=0, core_ready_o=0 and ret_ready_o=0 are forced combinationally.
- Blocking terms:
  - block_all = freeze_i.
  - block_st = core_is_store_i & ((state!=IDLE) | (count==max_out_p)).
  - Loads (core_is_store_i=0) still pass during a fence.
- Datapath handshake (combinational, no added latency):
  - net_v_o = core_v_i & ~block_all & ~block_st.
  - core_ready_o = net_ready_i & ~block_all & ~block_st.
  - net_v_o must not depend on net_ready_i.
- Counter update:
  - inc = core_v_i & core_is_store_i & core_ready_o.
  - dec = ret_v_i & ret_ready_o; ret_ready_o=1 whenever reset_i=1.
  - inc&dec: count unchanged.
  - inc only: count+1. Never exceeds max_out_p because blocking prevents it.
  - dec only with count>0: count−1.
  - dec only with count==0: count stays 0, err_underflow_o sets.
- Credits freed by an ack become visible the next cycle. There is no same-cycle bypass at count==max_out_p.
- FSM (Moore; fence_done_o registered from state):
  - IDLE: fence_req_i=1 → DRAIN. fence_req_i is ignored in every other state.
  - DRAIN:
    - count==0 (registered value) → DONE.
    - Otherwise the watchdog increments and saturates at timeout_p.
    - When it reaches timeout_p (and timeout_p≠0), err_timeout_o sets and the state remains DRAIN.
  - DONE: fence_done_o=1 for exactly this cycle; watchdog clears; → IDLE.
- Fence latency: fence_req_i at cycle t with count already 0 → DRAIN at t+1, fence_done_o=1 at t+2.
- Last ack during DRAIN: accepted at cycle t → count 0 at t+1 → fence_done_o=1 at t+2.
- freeze_i does not stall the FSM; acks are still accepted while frozen.
- Error flags clear only on reset.
- outstanding_o is the registered count.

Test Plan:
1. Reset, then 3 stores accepted back-to-back with net_ready_i=1, no acks → outstanding_o=3; 3 acks → 0; no errors.
2. max_out_p=4, 6 stores offered continuously with no acks:
   - 4 accepted, then core_ready_o=0 and net_v_o=0.
   - One ack at cycle t → 5th store accepted at t+1; outstanding_o=4.
3. Store and ack in the same cycle at count=4 (max) → store blocked, count 3 next cycle. Store and ack in the same cycle at count=2 → count stays 2.
4. Fence with count=2:
   - Stores blocked and loads pass during DRAIN.
   - Acks at cycles 10 and 14 → fence_done_o pulses at cycle 16 only; state returns to IDLE.
   - A fence with count=0 yields fence_done_o at t+2.
5. timeout_p=8, fence with count=1, no ack → err_timeout_o=1 after 8 DRAIN cycles. A later ack → fence_done_o two cycles later; err_timeout_o stays 1.
6. Ack with count=0 → err_underflow_o=1 and count stays 0. Assert reset_i=0 mid-DRAIN with count=3 → immediately count=0, IDLE, flags=0, net_v_o=0.
